// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue (ifq_fifo, instr_fetch_queue).
package ifq_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;

    localparam logic [OP_W-1:0]    OP_RTYPE  = 6'b000000;
    localparam logic [OP_W-1:0]    OP_ADDI   = 6'b001000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } ifq_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ifq_state_e;

    // FSM state and response-PC pointer kept together so they can be probed as one unit.
    typedef struct packed {
        ifq_state_e         state;
        logic [INSTR_W-1:0] fetch_pc;
    } ifq_ctrl_t;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
        return {a[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// In-order instruction buffer: registered storage, wrapping pointers, flush, and a
// head that reads as NOP_INSTR/pc 0 when empty.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  ifq_entry_t               push_data_i,
    input  logic                     pop_i,
    output ifq_entry_t               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    // A push into a full queue is accepted only when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign head_o = empty_o ? '{instr: NOP_INSTR, pc: '0} : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC, credit-limited imem requests, in-order response queue, redirect/flush.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [5:0]  op_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: imem request is taken on req && gnt; decode takes the head on valid && ready.
    // A redirect voids any decode handshake in its cycle.
    ifq_ctrl_t     ctrl_q, ctrl_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW:0]   credit_used;
    logic          run, credit_ok, issue, push, pop;
    logic          fifo_empty, fifo_full;
    ifq_entry_t    head, resp_entry, out_entry;

    assign run         = (ctrl_q.state == RUN);
    assign credit_used = {1'b0, count} + {1'b0, outst_q};
    assign credit_ok   = credit_used < (CW + 1)'(DEPTH);
    assign imem_req_o  = rst_i && run && credit_ok;
    assign imem_addr_o = pc_q;
    assign issue       = imem_req_o && imem_gnt_i;

    // Only one of these is non-zero at a time: outstanding in RUN, drop count in FLUSH.
    assign inflight   = outst_q + drop_q;
    assign resp_entry = '{instr: imem_rdata_i, pc: ctrl_q.fetch_pc};

`ifdef IFQ_BYPASS_EN
    logic byp;
    assign byp           = run && fifo_empty && imem_rvalid_i && !redirect_i;
    assign instr_valid_o = !fifo_empty || byp;
    assign out_entry     = byp ? resp_entry : head;
    assign push          = run && imem_rvalid_i && !redirect_i && !(byp && instr_ready_i);
`else
    assign instr_valid_o = !fifo_empty;
    assign out_entry     = head;
    assign push          = run && imem_rvalid_i && !redirect_i;
`endif

    assign pop        = !fifo_empty && instr_ready_i && !redirect_i;
    assign instr_o    = out_entry.instr;
    assign instr_pc_o = out_entry.pc;
    assign op_o       = out_entry.instr[31:26];

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (push),
        .push_data_i (resp_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    always_comb begin
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (redirect_i) begin
            // Everything still in flight, including a grant taken this cycle, belongs to the old stream.
            pc_d            = word_align(redirect_pc_i);
            ctrl_d.fetch_pc = word_align(redirect_pc_i);
            outst_d         = '0;
            drop_d          = inflight + CW'(issue) - CW'(imem_rvalid_i);
            ctrl_d.state    = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            case (ctrl_q.state)
                RUN: begin
                    if (issue)         pc_d            = pc_q + 32'd4;
                    if (imem_rvalid_i) ctrl_d.fetch_pc = ctrl_q.fetch_pc + 32'd4;
                    outst_d = outst_q + CW'(issue) - CW'(imem_rvalid_i);
                end
                FLUSH: begin
                    if (imem_rvalid_i) drop_d = drop_q - CW'(1);
                    if (drop_d == '0)  ctrl_d.state = RUN;
                end
                default: ctrl_d.state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl_q  <= '{state: RUN, fetch_pc: RESET_PC};
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    rvalid_has_fetch: assert property (@(posedge clk_i) disable iff (!rst_i)
        imem_rvalid_i |-> (inflight != '0))
        else $error("imem response with no fetch in flight");

    push_has_room: assert property (@(posedge clk_i) disable iff (!rst_i)
        push |-> (!fifo_full || pop))
        else $error("queue push with no free entry");

endmodule
